// File: rtl/bp_pkg.sv
// Shared branch-predictor package: default BTB geometry, entry layout and
// tree-PLRU helpers sized for up to 8 ways (7 tree bits, 3-bit way index).
package bp_pkg;

  localparam int BTB_PC_W   = 32;
  localparam int BTB_NSET   = 64;
  localparam int BTB_NWAY   = 4;
  localparam int BTB_TAG_W  = 20;
  localparam int PLRU_BITS  = 7;
  localparam int PLRU_WAY_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
  } btb_entry_t;

  function automatic int plru_levels(input int nway);
    return (nway >= 8) ? 3 : (nway >= 4) ? 2 : 1;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  // A bit of 0 points the victim search left, 1 points it right.
  function automatic logic [PLRU_WAY_W-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits,
                                                        input int nway);
    logic [2:0] node;
    logic [2:0] w;
    int         lv;
    node = '0;
    w    = '0;
    lv   = plru_levels(nway);
    for (int l = 0; l < PLRU_WAY_W; l++) begin
      if (l < lv) begin
        w    = {w[1:0], bits[node]};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b0, bits[node]};
      end
    end
    return w;
  endfunction

  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] bits,
                                                      input logic [PLRU_WAY_W-1:0] way,
                                                      input int nway);
    logic [PLRU_BITS-1:0] nb;
    logic [2:0]           node;
    logic [2:0]           wl;
    int                   lv;
    nb   = bits;
    node = '0;
    lv   = plru_levels(nway);
    wl   = way << (PLRU_WAY_W - lv);
    for (int l = 0; l < PLRU_WAY_W; l++) begin
      if (l < lv) begin
        nb[node] = ~wl[2];
        node     = {node[1:0], 1'b0} + 3'd1 + {2'b0, wl[2]};
        wl       = wl << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/bp_btb_plru.sv
// Per-set tree-PLRU state with an update touch, a lookup touch (applied after
// the update touch when both hit one set) and a victim read for the update set.
module bp_btb_plru
  import bp_pkg::*;
#(
  parameter int NSET = BTB_NSET,
  parameter int NWAY = BTB_NWAY,
  localparam int IDX_W = $clog2(NSET),
  localparam int WAY_W = $clog2(NWAY)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             upd_touch,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             lkp_touch,
  input  logic [IDX_W-1:0] lkp_idx,
  input  logic [WAY_W-1:0] lkp_way,
  output logic [WAY_W-1:0] vic_way
);

  logic [PLRU_BITS-1:0] bits [NSET];
  logic [PLRU_BITS-1:0] b_upd, b_lkp;

  always_comb begin
    b_upd = bits[upd_idx];
    if (upd_touch) b_upd = plru_touch(b_upd, PLRU_WAY_W'(upd_way), NWAY);
    b_lkp = (upd_touch && (lkp_idx == upd_idx)) ? b_upd : bits[lkp_idx];
    b_lkp = plru_touch(b_lkp, PLRU_WAY_W'(lkp_way), NWAY);
  end

  assign vic_way = WAY_W'(plru_victim(bits[upd_idx], NWAY));

  // The lookup write is last so it wins on a shared set; b_lkp already folds in the update touch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NSET; s++) bits[s] <= '0;
    end else begin
      if (upd_touch) bits[upd_idx] <= b_upd;
      if (lkp_touch) bits[lkp_idx] <= b_lkp;
    end
  end

endmodule

// File: rtl/bp_btb_assoc.sv
// Set-associative BTB: 1-cycle lookup with same-cycle update bypass, training
// with invalid-first / PLRU allocation. Optional perf counters: BTB_PERF_CNT_EN.
module bp_btb_assoc
  import bp_pkg::*;
#(
  parameter int PC_W  = BTB_PC_W,
  parameter int NSET  = BTB_NSET,
  parameter int NWAY  = BTB_NWAY,
  parameter int TAG_W = BTB_TAG_W,
  localparam int IDX_W = $clog2(NSET),
  localparam int WAY_W = $clog2(NWAY)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic [PC_W-1:0]  resp_target,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0]      perf_lookup_cnt,
  output logic [31:0]      perf_hit_cnt,
`endif
  input  logic             upd_valid,
  input  logic             upd_inv,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [PC_W-1:0]  upd_target
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } entry_t;

  entry_t [NWAY-1:0] mem [NSET];
  entry_t [NWAY-1:0] u_set, u_nxt, r_set;

  logic [IDX_W-1:0] u_idx, r_idx;
  logic [TAG_W-1:0] u_tag, r_tag;
  logic             u_hit, has_inv, r_hit, lkp_hit, upd_touch;
  logic [WAY_W-1:0] u_hway, inv_way, wr_way, vic_way, r_way;
  logic             unused_pc;

  assign u_idx     = upd_pc[2 +: IDX_W];
  assign u_tag     = upd_pc[2 + IDX_W +: TAG_W];
  assign r_idx     = req_pc[2 +: IDX_W];
  assign r_tag     = req_pc[2 + IDX_W +: TAG_W];
  assign unused_pc = ^{req_pc, upd_pc};
  assign upd_touch = upd_valid & ~upd_inv;

  always_comb begin
    u_set   = mem[u_idx];
    u_hit   = 1'b0;
    u_hway  = '0;
    has_inv = 1'b0;
    inv_way = '0;
    // Descending scan leaves the lowest matching / invalid way selected.
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (u_set[w].valid && (u_set[w].tag == u_tag)) begin
        u_hit  = 1'b1;
        u_hway = WAY_W'(w);
      end
      if (!u_set[w].valid) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    wr_way = u_hit ? u_hway : (has_inv ? inv_way : vic_way);
    u_nxt  = u_set;
    if (upd_valid) begin
      if (upd_inv) begin
        if (u_hit) u_nxt[u_hway].valid = 1'b0;
      end else begin
        u_nxt[wr_way] = {1'b1, u_tag, upd_target};
      end
    end
  end

  // Lookup sees the set as it will be after this cycle's update.
  always_comb begin
    r_set = (upd_valid && (u_idx == r_idx)) ? u_nxt : mem[r_idx];
    r_hit = 1'b0;
    r_way = '0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (r_set[w].valid && (r_set[w].tag == r_tag)) begin
        r_hit = 1'b1;
        r_way = WAY_W'(w);
      end
    end
    lkp_hit = req_valid & r_hit;
  end

  bp_btb_plru #(.NSET(NSET), .NWAY(NWAY)) u_plru (
    .clk       (clk),
    .resetn    (resetn),
    .upd_touch (upd_touch),
    .upd_idx   (u_idx),
    .upd_way   (wr_way),
    .lkp_touch (lkp_hit),
    .lkp_idx   (r_idx),
    .lkp_way   (r_way),
    .vic_way   (vic_way)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NSET; s++) mem[s] <= '0;
    end else if (upd_valid) begin
      mem[u_idx] <= u_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_target <= '0;
    end else begin
      resp_valid  <= req_valid;
      resp_hit    <= lkp_hit;
      resp_way    <= lkp_hit ? r_way : '0;
      resp_target <= lkp_hit ? r_set[r_way].target : '0;
    end
  end

`ifdef BTB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lookup_cnt <= '0;
      perf_hit_cnt    <= '0;
    end else begin
      if (req_valid && (perf_lookup_cnt != '1)) perf_lookup_cnt <= perf_lookup_cnt + 32'd1;
      if (lkp_hit && (perf_hit_cnt != '1))      perf_hit_cnt    <= perf_hit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_btb_assoc.sv
// Directed table-driven bench for bp_btb_assoc (default geometry 64 sets x 4 ways).
module tb_bp_btb_assoc;

  logic        clk, resetn;
  logic        req_valid, upd_valid, upd_inv;
  logic [31:0] req_pc, upd_pc, upd_target;
  logic        resp_valid, resp_hit;
  logic [1:0]  resp_way;
  logic [31:0] resp_target;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_lookup_cnt, perf_hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bp_btb_assoc dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .resp_valid      (resp_valid),
    .resp_hit        (resp_hit),
    .resp_way        (resp_way),
    .resp_target     (resp_target),
`ifdef BTB_PERF_CNT_EN
    .perf_lookup_cnt (perf_lookup_cnt),
    .perf_hit_cnt    (perf_hit_cnt),
`endif
    .upd_valid       (upd_valid),
    .upd_inv         (upd_inv),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv, ui;
    logic [31:0] upc, utgt;
    logic        rv;
    logic [31:0] rpc;
    logic        ev, eh;
    logic [1:0]  ew;
    logic [31:0] et;
  } vec_t;

  vec_t vecs[$];

  // Set-0 pcs (pc[7:2]=0) with distinct tags.
  localparam logic [31:0] PA = 32'h1000, PB = 32'h2000, PC = 32'h3000,
                          PD = 32'h4000, PE = 32'h5000, PF = 32'h6000;

  task automatic add(input logic uv, ui, input logic [31:0] upc, utgt,
                     input logic rv, input logic [31:0] rpc,
                     input logic ev, eh, input logic [1:0] ew, input logic [31:0] et);
    vec_t v;
    v = '{uv, ui, upc, utgt, rv, rpc, ev, eh, ew, et};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic uv, ui, input logic [31:0] upc, utgt,
                       input logic rv, input logic [31:0] rpc);
    upd_valid = uv; upd_inv = ui; upd_pc = upc; upd_target = utgt;
    req_valid = rv; req_pc = rpc;
  endtask

  task automatic check_resp(input string name, input logic ev, eh,
                            input logic [1:0] ew, input logic [31:0] et);
    checks++;
    if ({resp_valid, resp_hit, resp_way, resp_target} !== {ev, eh, ew, et}) begin
      errors++;
      $display("FAIL %s: got v=%b h=%b w=%0d t=%h, expected v=%b h=%b w=%0d t=%h",
               name, resp_valid, resp_hit, resp_way, resp_target, ev, eh, ew, et);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    add(0,0,0,0,                     1,32'h1C000000, 1,0,0,0);
    add(1,0,32'h1C000010,32'h1C000100, 0,0,         0,0,0,0);
    add(0,0,0,0,                     1,32'h1C000010, 1,1,0,32'h1C000100);
    add(1,0,32'h1C000020,32'h1C000200, 1,32'h1C000020, 1,1,0,32'h1C000200);
    // fill set 0: ways 0..3
    add(1,0,PA,32'hA0, 0,0, 0,0,0,0);
    add(1,0,PB,32'hB0, 0,0, 0,0,0,0);
    add(1,0,PC,32'hC0, 0,0, 0,0,0,0);
    add(1,0,PD,32'hD0, 0,0, 0,0,0,0);
    // hit 2,0,1: tree then points at way 3
    add(0,0,0,0, 1,PC, 1,1,2,32'hC0);
    add(0,0,0,0, 1,PA, 1,1,0,32'hA0);
    add(0,0,0,0, 1,PB, 1,1,1,32'hB0);
    add(1,0,PE,32'hE0, 0,0, 0,0,0,0);
    add(0,0,0,0, 1,PD, 1,0,0,0);
    add(0,0,0,0, 1,PE, 1,1,3,32'hE0);
    add(0,0,0,0, 0,PA, 0,0,0,0);
    // invalidate resident B, then an absent pc
    add(1,1,PB,0, 0,0, 0,0,0,0);
    add(0,0,0,0, 1,PB, 1,0,0,0);
    add(0,0,0,0, 1,PA, 1,1,0,32'hA0);
    add(1,1,32'h9000,0, 0,0, 0,0,0,0);
    add(0,0,0,0, 1,PC, 1,1,2,32'hC0);
    add(0,0,0,0, 1,PE, 1,1,3,32'hE0);
    add(1,1,PA,0, 1,PA, 1,0,0,0);
    // overwrite target, pc[1:0] ignored, invalid-first allocation
    add(1,0,PC,32'hC4, 0,0, 0,0,0,0);
    add(0,0,0,0, 1,PC, 1,1,2,32'hC4);
    add(0,0,0,0, 1,PC | 32'h3, 1,1,2,32'hC4);
    add(1,0,PF,32'hF0, 0,0, 0,0,0,0);
    add(0,0,0,0, 1,PF, 1,1,0,32'hF0);

    repeat (2) @(negedge clk);
    check_resp("reset_state", 0, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].uv, vecs[i].ui, vecs[i].upc, vecs[i].utgt, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      check_resp($sformatf("row%0d", i), vecs[i].ev, vecs[i].eh, vecs[i].ew, vecs[i].et);
    end

    // In-flight hit, then asynchronous reset drops it and clears storage.
    drive(0, 0, 0, 0, 1, PC);
    @(posedge clk); #1;
    check_resp("pre_reset_hit", 1, 1, 2, 32'hC4);
    resetn = 1'b0;
    #1;
    check_resp("async_reset_resp", 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    check_resp("first_resp_after_reset", 0, 0, 0, 0);
    @(negedge clk);
    check_resp("post_reset_miss", 1, 0, 0, 0);

`ifdef BTB_PERF_CNT_EN
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_val("perf_lookup_reset", perf_lookup_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 0, 32'h1C000040, 32'h44, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, (i % 2 == 1 && i < 8) ? 32'h1C000040 : 32'h1C000080);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    check_val("perf_lookup_10", perf_lookup_cnt, 32'd10);
    check_val("perf_hit_4", perf_hit_cnt, 32'd4);
    drive(0, 0, 0, 0, 1, 32'h1C000040);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check_val("perf_lookup_async", perf_lookup_cnt, 0);
    check_val("perf_hit_async", perf_hit_cnt, 0);
    check_resp("perf_async_resp", 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_resp("perf_valid_cleared", 1, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
